// File: rtl/io_output_bank.sv
// ============================================================================
// io_output_bank : memory-mapped output ports with set/clear/toggle writes,
//                  per-port auto-clear pulse mode and registered readback.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module io_output_bank #(
  parameter int         NUM_PORTS    = 4,
  parameter int         WIDTH        = 32,
  parameter logic [7:0] BASE_ADDR    = 8'h80,
  parameter logic [7:0] CTRL_ADDR    = 8'hC0,
  parameter int         PULSE_CYCLES = 16
) (
  input  logic                       io_clk,
  input  logic                       resetn,
  input  logic [31:0]                addr,
  input  logic [31:0]                datain,
  input  logic                       write_io_enable,
  input  logic [31:0]                rd_addr,
  output logic [31:0]                rd_data,
  output logic [NUM_PORTS*WIDTH-1:0] out_port,
  output logic [NUM_PORTS-1:0]       port_update,
  output logic [NUM_PORTS-1:0]       pulse_mask
);

  localparam int         c_CW       = $clog2(PULSE_CYCLES + 1);
  localparam logic [5:0] c_CTRL_SEL = CTRL_ADDR[7:2];
  localparam logic [5:0] c_BASE_SEL = BASE_ADDR[7:2];

  logic [1:0]           w_mode;
  logic [WIDTH-1:0]     w_wdata;
  logic                 w_ctrl_wr;
  logic [NUM_PORTS-1:0] pulse_mask_q;
  logic [NUM_PORTS-1:0] pulse_mask_d;
  logic [31:0]          rd_data_q;
  logic [31:0]          rd_data_d;
  logic                 w_unused_ok;

  assign w_mode    = addr[9:8];
  assign w_wdata   = datain[WIDTH-1:0];
  assign w_ctrl_wr = write_io_enable && (addr[7:2] == c_CTRL_SEL) && (w_mode == 2'b00);

  always_comb begin
    pulse_mask_d = pulse_mask_q;
    if (w_ctrl_wr) pulse_mask_d = datain[NUM_PORTS-1:0];
  end

  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      localparam logic [5:0] c_PORT_SEL = c_BASE_SEL + 6'(i);

      logic [WIDTH-1:0] port_q, port_d, w_wval;
      logic [c_CW-1:0]  cnt_q, cnt_d;
      logic             upd_q, upd_d;
      logic             w_hit, w_expire;

      assign w_hit = write_io_enable && (addr[7:2] == c_PORT_SEL);
      // Using the next mask value means a mask clear on the expiry edge suppresses the auto-clear.
      assign w_expire = pulse_mask_d[i] && (cnt_q == c_CW'(1));

      always_comb begin
        w_wval = w_wdata;
        case (w_mode)
          2'b00:   w_wval = w_wdata;
          2'b01:   w_wval = port_q | w_wdata;
          2'b10:   w_wval = port_q & ~w_wdata;
          default: w_wval = port_q ^ w_wdata;
        endcase
      end

      always_comb begin
        port_d = port_q;
        cnt_d  = '0;
        if (w_hit)         port_d = w_wval;
        else if (w_expire) port_d = '0;

        if (!pulse_mask_d[i]) cnt_d = '0;
        else if (w_hit)       cnt_d = c_CW'(PULSE_CYCLES);
        else if (cnt_q != '0) cnt_d = cnt_q - c_CW'(1);
        upd_d = (port_d != port_q);
      end

      always_ff @(posedge io_clk) begin
        if (!resetn) begin
          port_q <= '0;
          cnt_q  <= '0;
          upd_q  <= 1'b0;
        end else begin
          port_q <= port_d;
          cnt_q  <= cnt_d;
          upd_q  <= upd_d;
        end
      end

      assign out_port[i*WIDTH +: WIDTH] = port_q;
      assign port_update[i]             = upd_q;
    end
  endgenerate

  // Readback samples the pre-write port state, so same-edge writes show a cycle later.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rd_addr[7:2] == (c_BASE_SEL + 6'(i))) rd_data_d[WIDTH-1:0] = out_port[i*WIDTH +: WIDTH];
    end
    if (rd_addr[7:2] == c_CTRL_SEL) rd_data_d[NUM_PORTS-1:0] = pulse_mask_q;
  end

  always_ff @(posedge io_clk) begin
    if (!resetn) begin
      pulse_mask_q <= '0;
      rd_data_q    <= '0;
    end else begin
      pulse_mask_q <= pulse_mask_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign pulse_mask  = pulse_mask_q;
  assign w_unused_ok = ^{addr, datain, rd_addr};

endmodule

`default_nettype wire
